int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 157 +++++++++++++++
 tb/tb_int_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: edge/level channels, fixed-stride vectors, IDLE/REQ/SVC FSM.
// Optional nested preemption is enabled by defining INT_NEST_EN.
module int_ctrl #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned VEC_W       = 8,
    parameter logic [VEC_W-1:0] VEC_BASE   = 'h80,
    parameter logic [VEC_W-1:0] VEC_STRIDE = 'h10,
    parameter int unsigned NEST_DEPTH  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  irq,
    input  logic [N_CH-1:0]  irq_edge,
    input  logic [N_CH-1:0]  int_mask,
    input  logic             glb_en,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic [2:0]       active_ch,
    output logic             busy,
    output logic [N_CH-1:0]  pending
);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

    state_t           state_q, state_d;
    logic [N_CH-1:0]  irq_q;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  pend_view;
    logic [N_CH-1:0]  elig;
    logic [7:0]       elig8;
    logic [7:0]       ack_oh;
    logic [N_CH-1:0]  clr;
    logic             any_elig;
    logic [2:0]       sel_c, sel_q;
    logic [VEC_W-1:0] int_vec_q;
    logic [2:0]       active_q;
    logic             busy_q;
    logic             take_ack;
    logic             do_ret;
    logic             load_sel;
    logic             preempt;

`ifdef INT_NEST_EN
    localparam int unsigned DW = $clog2(NEST_DEPTH + 1);
    logic [NEST_DEPTH-1:0][2:0] stack_q;
    logic [DW-1:0]              depth_q;
    logic                       nested;
    assign nested  = (depth_q != '0);
    assign preempt = any_elig && (sel_c < active_q) && (depth_q < DW'(NEST_DEPTH));
`else
    logic nested;
    assign nested  = 1'b0;
    assign preempt = 1'b0;
`endif

    // Level channels mirror irq_q directly; only edge channels hold a sticky bit.
    assign pend_view = (pend_q & irq_edge) | (irq_q & ~irq_edge);
    assign elig      = pend_view & int_mask & {N_CH{glb_en}};
    assign elig8     = 8'(elig);
    assign any_elig  = |elig;
    assign ack_oh    = 8'd1 << sel_q;

    always_comb begin
        sel_c = 3'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (elig[i]) sel_c = 3'(i);
        end
    end

    assign take_ack = (state_q == REQ) && int_ack;
    assign do_ret   = (state_q == SVC) && int_ret;
    assign load_sel = ((state_q == IDLE) && any_elig) ||
                      ((state_q == SVC) && !int_ret && preempt);

    assign clr    = take_ack ? ack_oh[N_CH-1:0] : '0;
    // A new edge in the ack cycle must survive the clear.
    assign pend_d = ((pend_q & ~clr) | (irq & ~irq_q)) & irq_edge;

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any_elig) state_d = REQ;
            REQ: begin
                if (int_ack)             state_d = SVC;
                else if (!elig8[sel_q])  state_d = busy_q ? SVC : IDLE;
            end
            SVC: begin
                if (int_ret)      state_d = nested ? SVC : IDLE;
                else if (preempt) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int_req   = (state_q == REQ);
        int_vec   = int_vec_q;
        active_ch = active_q;
        busy      = busy_q;
        pending   = pend_view;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q     <= '0;
            pend_q    <= '0;
            sel_q     <= 3'd0;
            int_vec_q <= '0;
            active_q  <= 3'd0;
            busy_q    <= 1'b0;
        end else begin
            irq_q  <= irq;
            pend_q <= pend_d;
            if (load_sel) begin
                sel_q     <= sel_c;
                int_vec_q <= VEC_BASE + VEC_W'(sel_c) * VEC_STRIDE;
            end
            if (take_ack) begin
                active_q <= sel_q;
                busy_q   <= 1'b1;
            end else if (do_ret) begin
`ifdef INT_NEST_EN
                if (nested) active_q <= stack_q[0];
                else        busy_q   <= 1'b0;
`else
                busy_q <= 1'b0;
`endif
            end
        end
    end

`ifdef INT_NEST_EN
    // Shift-register stack: entry 0 is the most recently preempted channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            stack_q <= '0;
            depth_q <= '0;
        end else if (take_ack && busy_q) begin
            for (int i = NEST_DEPTH - 1; i >= 1; i--) stack_q[i] <= stack_q[i-1];
            stack_q[0] <= active_q;
            depth_q    <= depth_q + DW'(1);
        end else if (do_ret && nested) begin
            for (int i = 0; i < NEST_DEPTH - 1; i++) stack_q[i] <= stack_q[i+1];
            stack_q[NEST_DEPTH-1] <= 3'd0;
            depth_q               <= depth_q - DW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: stimulus pushes expected request vectors and arrival cycles,
// a negedge monitor pops them on every rising int_req.
module tb_int_ctrl;

    logic       clock;
    logic       reset;
    logic [3:0] irq;
    logic [3:0] irq_edge;
    logic [3:0] int_mask;
    logic       glb_en;
    logic       int_ack;
    logic       int_ret;
    logic       int_req;
    logic [7:0] int_vec;
    logic [2:0] active_ch;
    logic       busy;
    logic [3:0] pending;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] vec;
        int         at;
    } exp_t;
    exp_t sb[$];

    int_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .irq       (irq),
        .irq_edge  (irq_edge),
        .int_mask  (int_mask),
        .glb_en    (glb_en),
        .int_ack   (int_ack),
        .int_ret   (int_ret),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .active_ch (active_ch),
        .busy      (busy),
        .pending   (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_req(input logic [7:0] vec, input int delay);
        exp_t e;
        e.vec = vec;
        e.at  = cyc + delay;
        sb.push_back(e);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        int_ret = 1'b1;
        step(1);
        int_ret = 1'b0;
    endtask

    // Monitor: each new request must match the oldest expectation in value and cycle.
    initial begin
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clock);
            if (int_req && !prev_req) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL req_unexpected: got vec=%0h at cycle %0d, none expected",
                             int_vec, cyc);
                end else begin
                    e = sb.pop_front();
                    if (int_vec !== e.vec || cyc != e.at) begin
                        bad++;
                        $display("FAIL req_vec: got vec=%0h cycle=%0d expected vec=%0h cycle=%0d",
                                 int_vec, cyc, e.vec, e.at);
                    end
                end
            end
            prev_req = int_req;
        end
    end

    initial begin
        reset    = 1'b1;
        irq      = 4'h0;
        irq_edge = 4'hF;
        int_mask = 4'hF;
        glb_en   = 1'b1;
        int_ack  = 1'b0;
        int_ret  = 1'b0;
        step(2);
        chk("rst_req", int_req, 0);
        chk("rst_vec", int_vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active", active_ch, 0);
        chk("rst_pending", pending, 0);
        reset = 1'b0;
        step(2);

        // Single edge on ch2.
        irq = 4'b0100;
        expect_req(8'hA0, 2);
        step(1);
        irq = 4'h0;
        chk("t1_pending_set", pending, 4'b0100);
        chk("t1_req_not_yet", int_req, 0);
        step(1);
        chk("t1_req", int_req, 1);
        step(1);
        chk("t1_req_held", int_req, 1);
        chk("t1_vec_frozen", int_vec, 8'hA0);
        pulse_ack();
        chk("t1_req_drop", int_req, 0);
        chk("t1_busy", busy, 1);
        chk("t1_active", active_ch, 2);
        chk("t1_pending_clr", pending, 0);
        pulse_ret();
        chk("t1_idle_busy", busy, 0);
        step(2);

        // Simultaneous edges on ch3 and ch1: ch1 wins, ch3 follows after ret.
        irq = 4'b1010;
        expect_req(8'h90, 2);
        step(1);
        irq = 4'h0;
        step(1);
        chk("t2_pending", pending, 4'b1010);
        pulse_ack();
        chk("t2_active", active_ch, 1);
        chk("t2_pending_left", pending, 4'b1000);
        chk("t2_no_req_in_svc", int_req, 0);
        expect_req(8'hB0, 2);
        pulse_ret();
        chk("t2_ret_idle", busy, 0);
        step(1);
        pulse_ack();
        chk("t2_active3", active_ch, 3);
        chk("t2_pending_empty", pending, 0);
        pulse_ret();
        step(2);

        // Level ch0: re-request after ret, then withdraw when the line drops.
        irq_edge = 4'b1110;
        irq = 4'b0001;
        expect_req(8'h80, 2);
        step(2);
        pulse_ack();
        chk("t3_level_pending", pending, 4'b0001);
        chk("t3_busy", busy, 1);
        expect_req(8'h80, 2);
        pulse_ret();
        chk("t3_req_low_idle", int_req, 0);
        chk("t3_busy_idle", busy, 0);
        step(1);
        chk("t3_rereq", int_req, 1);
        irq = 4'h0;
        step(1);
        chk("t3_req_still", int_req, 1);
        step(1);
        chk("t3_withdrawn", int_req, 0);
        chk("t3_no_svc", busy, 0);
        chk("t3_pending_gone", pending, 0);
        step(1);
        chk("t3_stays_idle", int_req, 0);
        irq_edge = 4'hF;
        step(1);

        // Reset while in service with ch1 pending.
        irq = 4'b0010;
        expect_req(8'h90, 2);
        step(1);
        irq = 4'h0;
        step(1);
        pulse_ack();
        irq = 4'b0010;
        step(1);
        irq = 4'h0;
        chk("t4_pending_in_svc", pending, 4'b0010);
        reset = 1'b1;
        step(1);
        chk("t4_rst_req", int_req, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_pending", pending, 0);
        chk("t4_rst_vec", int_vec, 0);
        chk("t4_rst_active", active_ch, 0);

        // Line already high at reset release counts as an edge.
        irq = 4'b1000;
        step(1);
        chk("t5_pending_in_rst", pending, 0);
        reset = 1'b0;
        expect_req(8'hB0, 2);
        step(1);
        chk("t5_edge_after_rst", pending, 4'b1000);
        step(1);
        irq = 4'h0;
        pulse_ack();
        pulse_ret();
        step(2);

        // Withdraw on mask, re-request, then ack wins over glb_en drop and new edge wins over clear.
        irq = 4'b0100;
        expect_req(8'hA0, 2);
        step(1);
        irq = 4'h0;
        step(1);
        int_mask = 4'h0;
        step(1);
        chk("t6_mask_withdraw", int_req, 0);
        chk("t6_pending_kept", pending, 4'b0100);
        int_mask = 4'hF;
        expect_req(8'hA0, 1);
        step(1);
        glb_en  = 1'b0;
        irq     = 4'b0100;
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        glb_en  = 1'b1;
        irq     = 4'h0;
        chk("t6_ack_wins", busy, 1);
        chk("t6_ack_active", active_ch, 2);
        chk("t6_set_wins", pending, 4'b0100);
        expect_req(8'hA0, 2);
        pulse_ret();
        step(1);
        pulse_ack();
        chk("t6_pending_clr", pending, 0);
        pulse_ret();
        step(2);

        // ch3 in service, edge on ch0.
        irq = 4'b1000;
        expect_req(8'hB0, 2);
        step(1);
        irq = 4'h0;
        step(1);
        pulse_ack();
        chk("t7_active3", active_ch, 3);
        irq = 4'b0001;
`ifdef INT_NEST_EN
        expect_req(8'h80, 2);
        step(1);
        irq = 4'h0;
        step(1);
        chk("t7_preempt_req", int_req, 1);
        chk("t7_preempt_busy", busy, 1);
        pulse_ack();
        chk("t7_nest_active0", active_ch, 0);
        chk("t7_nest_busy", busy, 1);
        pulse_ret();
        chk("t7_pop_active3", active_ch, 3);
        chk("t7_pop_busy", busy, 1);
        chk("t7_pop_no_req", int_req, 0);
        pulse_ret();
        chk("t7_final_idle", busy, 0);
`else
        step(1);
        irq = 4'h0;
        step(1);
        chk("t7_no_preempt", int_req, 0);
        chk("t7_still_busy", busy, 1);
        chk("t7_still_active3", active_ch, 3);
        chk("t7_ch0_pending", pending, 4'b0001);
        expect_req(8'h80, 2);
        pulse_ret();
        chk("t7_ret_idle", busy, 0);
        step(1);
        pulse_ack();
        chk("t7_active0", active_ch, 0);
        pulse_ret();
        chk("t7_final_idle", busy, 0);
`endif
        step(4);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
